systolic_output_collector: RTL
==============================

# systolic_output_collector

Downstream stage of the systolic output deskew buffer. It captures the `length` consecutive aligned result rows that leave the deskew buffer after a tile drains, holds them in a local row store, and replays them one row per handshake to the result memory writer over a valid/ready interface. A controller marks the first aligned row with a one-cycle `start` pulse, because the deskew path carries no valid signal.

## Interface
- `DATA_WIDTH`, 8, width of one result element.
- `length`, 16, array dimension: elements per row and rows per tile.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  one-cycle pulse; `din` in this cycle is row 0 of a tile.
- `din`  in  DATA_WIDTH*length  aligned row from the deskew buffer; element j at `din[DATA_WIDTH*(length-1-j)+:DATA_WIDTH]`.
- `out_valid`  out  1  `out_data` holds a valid row.
- `out_ready`  in  1  consumer accepts the row when high together with `out_valid`.
- `out_data`  out  DATA_WIDTH*length  row being offered; same element packing as `din`.
- `out_row`  out  $clog2(length)  index of the row on `out_data`.
- `busy`  out  1  high in CAPTURE and DRAIN.
- `done`  out  1  one-cycle pulse after the last row handshake.
- `overrun`  out  1  sticky; set when `start` arrives while busy. Cleared only by `rst`.

## Operation
- Row store: `length` registers, each DATA_WIDTH*length bits wide. Row counter `cnt` is $clog2(length) bits wide.
- States:
  - IDLE: `start` moves to CAPTURE, writes `din` to row 0 and sets `cnt`=1.
  - CAPTURE: each cycle writes `din` to row `cnt` and increments `cnt`. After row `length-1` is written, goes to DRAIN with `cnt`=0.
  - DRAIN: `out_valid`=1, `out_data`=row[`cnt`], `out_row`=`cnt`. On handshake `cnt` increments. The handshake on row `length-1` moves to IDLE and pulses `done` in the next cycle.
- CAPTURE has no backpressure. Rows are taken unconditionally on consecutive cycles; the controller guarantees this spacing.
- `start` in CAPTURE or DRAIN:
  - is ignored;
  - sets `overrun`;
  - does not disturb the capture or drain in progress.
- `start` in the same cycle as `done` is legal, because the state is IDLE, and begins a new tile.
- `out_data` and `out_row` stay stable while `out_valid`=1 and `out_ready`=0.
- Data passes through untouched. No arithmetic, no saturation.
- `rst` wins over every other input, including in the middle of CAPTURE or DRAIN. It:
  - returns the block to IDLE;
  - sets `cnt`=0;
  - drops any partial tile;
  - clears `overrun`.
- Row store contents need not be reset.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_row`=0, `busy`=0, `done`=0, `overrun`=0.
- With `start` at cycle t:
  - rows are captured at t through t+length-1;
  - `busy`=1 from t+1, registered;
  - `out_valid` rises at t+length with row 0.
- With `out_ready` held high:
  - one row per cycle;
  - last handshake at t+2·length-1;
  - `done`=1 and `busy`=0 at t+2·length.
- Stalls extend DRAIN one cycle per non-accepted cycle.
- `out_valid` never drops before its handshake.
- All outputs are registered.
- Minimum tile period with no stalls: 2·length cycles.

## Test plan
- Basic tile, length=16, DATA_WIDTH=8. Row r element j = 16r+j; `start` at cycle 10; `out_ready`=1. Required:
  - rows 0..15 appear in order at cycles 26..41;
  - `out_row` counts 0..15;
  - `done` at cycle 42 only.
- Backpressure: `out_ready` alternating 1/0 starting at 1 during DRAIN. Required:
  - each row is held stable while not accepted;
  - 16 handshakes total;
  - `done` one cycle after the 16th handshake;
  - no row skipped or duplicated.
- Overrun: second `start` at t+5 of a tile. Required:
  - `overrun`=1 from the next cycle and stays 1;
  - the first tile drains intact;
  - no second tile is captured.
- Back-to-back: new `start` in the `done` cycle. Required:
  - second tile rows (value 0xA0+r) emitted correctly after the first;
  - `overrun` stays 0.
- Reset mid-DRAIN: `rst` after 7 handshakes. Required:
  - next cycle `out_valid`=0, `busy`=0, `overrun`=0;
  - a fresh tile afterwards outputs from row 0.
- Extreme data: all elements 0xFF in one tile, then 0x00 in the next. Required: exact passthrough, with no bit-slice swap between element 0 and element 15.

Source files
------------

// File: rtl/systolic_output_collector.sv
// -----------------------------------------------------------------------------
// systolic_output_collector
//
// Sits behind the systolic output deskew buffer. When a tile drains, the
// controller pulses `start` alongside the first aligned row. The block then
// captures `length` consecutive rows into a local row store without stalling.
// It replays them one row per handshake to the result memory writer.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset (wins over every other input)
//   start      one-cycle pulse; `din` in this cycle is row 0 of a tile
//   din        aligned row, element j at din[DATA_WIDTH*(length-1-j) +: DATA_WIDTH]
//   out_valid  out_data/out_row hold a row offered to the consumer
//   out_ready  consumer accepts the offered row
//   out_data   offered row, same element packing as din
//   out_row    index of the offered row
//   busy       high while capturing or draining
//   done       one-cycle pulse in the cycle after the last row handshake
//   overrun    sticky flag: a start arrived while busy (cleared by rst only)
//   dbg_state  current FSM state (0 idle, 1 capture, 2 drain)
//
// Handshake: a row transfers in every cycle where out_valid and out_ready
// are both high. Once out_valid is raised it stays high, and out_data and
// out_row stay constant, until that transfer happens. out_ready may change
// freely and is never required to wait for out_valid.
//
// Every output is driven straight from a flop. The output comb process
// computes next values only.
// -----------------------------------------------------------------------------
module systolic_output_collector #(
    parameter int DATA_WIDTH = 8,
    parameter int length     = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [DATA_WIDTH*length-1:0]     din,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_WIDTH*length-1:0]     out_data,
    output logic [$clog2(length)-1:0]        out_row,
    output logic                             busy,
    output logic                             done,
    output logic                             overrun,
    output logic [1:0]                       dbg_state
);

    localparam int RW = DATA_WIDTH * length;
    localparam int CW = $clog2(length);
    localparam logic [CW-1:0] LAST = CW'(length - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DRAIN   = 2'd2
    } state_t;

    state_t          state;
    state_t          state_d;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_d;
    logic [CW-1:0]   cnt_inc;

    // Row store. Its contents are not reset. A reset only forgets the
    // tile through the state and cnt registers.
    logic [RW-1:0]   row_mem [length];
    logic            wr_en;
    logic [CW-1:0]   wr_idx;

    // Next values of the registered outputs
    logic            out_valid_d;
    logic [RW-1:0]   out_data_d;
    logic [CW-1:0]   out_row_d;
    logic            busy_d;
    logic            done_d;
    logic            overrun_d;

    logic            handshake;

    assign cnt_inc   = cnt + CW'(1);
    // out_valid mirrors state==S_DRAIN, so decode the handshake from the state
    assign handshake = (state == S_DRAIN) && out_ready;
    assign dbg_state = state;

    // -------------------------------------------------------------------------
    // State register. It also holds the counter and the registered outputs.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_row   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            out_valid <= out_valid_d;
            out_data  <= out_data_d;
            out_row   <= out_row_d;
            busy      <= busy_d;
            done      <= done_d;
            overrun   <= overrun_d;
        end
    end

    // Row store write port. Writes are suppressed under reset, so a reset
    // cycle never leaves a half-written row behind.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            row_mem[wr_idx] <= din;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE: begin
                if (start) state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                // Capture has no backpressure. It moves on once row length-1
                // has been written.
                if (cnt == LAST) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (out_ready && (cnt == LAST)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output / datapath next-value logic
    // -------------------------------------------------------------------------
    always_comb begin
        cnt_d       = cnt;
        wr_en       = 1'b0;
        wr_idx      = cnt;
        out_data_d  = out_data;
        out_row_d   = out_row;
        out_valid_d = (state_d == S_DRAIN);
        busy_d      = (state_d != S_IDLE);
        done_d      = handshake && (cnt == LAST);
        // A start is illegal while busy. Flag it and otherwise ignore it.
        overrun_d   = overrun | (start && (state != S_IDLE));

        case (state)
            S_IDLE: begin
                if (start) begin
                    wr_en  = 1'b1;
                    wr_idx = '0;
                    cnt_d  = CW'(1);
                end
            end
            S_CAPTURE: begin
                wr_en  = 1'b1;
                wr_idx = cnt;
                if (cnt == LAST) begin
                    // Row 0 was written cycles ago, so it can be offered
                    // now. Row length-1 is written at this same edge.
                    cnt_d      = '0;
                    out_data_d = row_mem[0];
                    out_row_d  = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_DRAIN: begin
                if (out_ready) begin
                    if (cnt == LAST) begin
                        cnt_d      = '0;
                        out_data_d = '0;
                        out_row_d  = '0;
                    end else begin
                        cnt_d      = cnt_inc;
                        out_data_d = row_mem[cnt_inc];
                        out_row_d  = cnt_inc;
                    end
                end
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

endmodule
